ram_dispatch: RTL

- Write-side counterpart of the 19-channel RAM enable select.
- Accepts one valid/ready data stream and distributes it frame by frame into the 19 channel RAMs.
- Produces a one-hot write enable, the write address and the write data.
- Advances round-robin to the next channel after each FRAME_LEN words; finishes after one frame per channel.

---
 rtl/ram_dispatch_pkg.sv | 9 +
 rtl/ram_ch_next.sv | 30 +++
 rtl/ram_dispatch.sv | 104 ++++++++++
 3 files changed

// File: rtl/ram_dispatch_pkg.sv
// ram_dispatch_pkg: shared channel constants, FSM state type and one-hot helper for the RAM dispatcher.
package ram_dispatch_pkg;
  localparam int NUM_CH = 19;
  localparam int CH_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction
endpackage

// File: rtl/ram_ch_next.sv
// ram_ch_next: combinational circular search for the next unmasked channel.
// Ports: cur (search origin), mask (1 = skip channel), incl (1 = cur itself is a candidate,
// 0 = start at cur+1), nxt (channel found), none (every channel masked).
module ram_ch_next
  import ram_dispatch_pkg::*;
(
  input  logic [CH_W-1:0]   cur,
  input  logic [NUM_CH-1:0] mask,
  input  logic              incl,
  output logic [CH_W-1:0]   nxt,
  output logic              none
);
  logic [CH_W-1:0] k;
  logic [NUM_CH-1:0] sh;
  // Scan offsets from farthest to nearest so the nearest unmasked channel is written last and wins.
  always_comb begin
    nxt = '0;
    none = 1'b1;
    k = '0;
    sh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = CH_W'((int'(cur) + i + int'(!incl)) % NUM_CH);
      sh = mask >> k;
      if (!sh[0]) begin
        nxt = k;
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/ram_dispatch.sv
// ram_dispatch: distributes a valid/ready word stream frame by frame, round-robin, into NUM_CH channel RAMs.
// Ports: clk, rst_n (sync, active low); start (pulse, IDLE only), abort (level, RUN only), first_ch;
// in_valid/in_ready/in_data input stream; wr_en (one-hot), wr_addr, wr_data registered RAM write;
// channel (channel being filled), busy (RUN), done (one-cycle end-of-pass pulse).
// Optional: define DISPATCH_MASK_EN to add ch_mask (1 = skip channel, sampled on start).
module ram_dispatch
  import ram_dispatch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int FRAME_LEN = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   first_ch,
`ifdef DISPATCH_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0] wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CH_W-1:0]   channel,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [CH_W-1:0] frames, total, first_sel, start_ch, adv_ch;
  logic [NUM_CH-1:0] mask_in, mask_q;
  logic start_none, adv_none, accept;
`ifdef DISPATCH_MASK_EN
  assign mask_in = ch_mask;
`else
  assign mask_in = '0;
  assign mask_q = '0;
`endif
  assign in_ready = (state == RUN) && !abort;
  assign accept = in_valid && in_ready;
  assign first_sel = first_ch >= CH_W'(NUM_CH) ? '0 : first_ch;
  ram_ch_next u_start (.cur(first_sel), .mask(mask_in), .incl(1'b1), .nxt(start_ch), .none(start_none));
  ram_ch_next u_adv (.cur(channel), .mask(mask_q), .incl(1'b0), .nxt(adv_ch), .none(adv_none));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_en <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      channel <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      addr <= '0;
      frames <= '0;
      total <= '0;
`ifdef DISPATCH_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      wr_en <= accept ? onehot(channel) : '0;
      if (accept) begin
        wr_addr <= addr;
        wr_data <= in_data;
      end
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          channel <= start_ch;
          addr <= '0;
          frames <= '0;
          total <= CH_W'(NUM_CH - $countones(mask_in));
`ifdef DISPATCH_MASK_EN
          mask_q <= ch_mask;
`endif
          state <= start_none ? DONE : RUN;
          busy <= !start_none;
          done <= start_none;
        end
        RUN: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (accept) begin
          addr <= addr == LAST ? '0 : addr + ADDR_W'(1);
          // The word just accepted is written to the old channel; the advance only affects later words.
          if (addr == LAST) begin
            frames <= frames + CH_W'(1);
            channel <= adv_ch;
            if (frames + CH_W'(1) == total || adv_none) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
